exu_jump_ctrl: RTL and testbench
================================

// Module: exu_jump_ctrl
// PURPOSE
//  Sequences the branch/jump resolution result from the EXU into a front-end redirect.
//  Sits between the EXU branch unit and the IFU:
//   - latches a taken target;
//   - performs a valid/ready redirect handshake with the IFU;
//   - asserts a pipeline flush, then inserts a programmable bubble window;
//   - flags misaligned targets and counts taken redirects.
// PARAMETERS
//  FLUSH_CYCLES  2   bubble cycles of flush held after the redirect handshake (legal 0..15)
//  CNT_W         32  width of the taken-redirect counter
// PORTS
//  i_clk             in   1      single clock; all state changes on rising edge
//  i_rst             in   1      synchronous reset, active-high
//  i_ex_valid        in   1      EX stage holds a valid instruction this cycle
//  i_jump_en         in   1      branch/jump resolved taken (qualified by i_ex_valid)
//  i_jump_addr       in   32     resolved target address (pc + imm)
//  i_ifu_ready       in   1      IFU accepts the redirect this cycle
//  i_cnt_clr         in   1      clear taken-redirect counter
//  o_redirect_valid  out  1      redirect request to IFU
//  o_redirect_pc     out  32     redirect target, stable while o_redirect_valid=1
//  o_flush           out  1      kill IF/ID (wrong-path) instructions
//  o_busy            out  1      controller not IDLE; EX requests ignored
//  o_misalign        out  1      one-cycle pulse: taken target with addr[1:0]!=0
//  o_misalign_addr   out  32     offending target, valid while o_misalign=1
//  o_taken_cnt       out  CNT_W  number of completed redirect handshakes
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal target and bubble counter 0.
//  All outputs are registered (driven from state/regs, no comb path from inputs).
//  States: IDLE, REQ, DRAIN.
//  IDLE:
//   - Request = i_ex_valid & i_jump_en.
//   - Request with i_jump_addr[1:0]==0:
//      - latch target; next cycle state=REQ;
//      - next cycle o_redirect_valid=1, o_flush=1, o_busy=1.
//      - Latency: request cycle T -> redirect visible at T+1.
//   - Request with i_jump_addr[1:0]!=0:
//      - next cycle o_misalign=1 for exactly one cycle, o_misalign_addr=target;
//      - no redirect, no flush, remain IDLE.
//   - i_jump_en with i_ex_valid=0: ignored.
//  REQ:
//   - o_redirect_valid=1, o_flush=1, o_busy=1.
//   - o_redirect_pc is held constant until the handshake.
//   - Handshake = o_redirect_valid & i_ifu_ready. On handshake:
//      - o_taken_cnt increments;
//      - FLUSH_CYCLES==0 -> IDLE; otherwise -> DRAIN with bubble counter=FLUSH_CYCLES.
//   - No handshake: stay in REQ indefinitely; no timeout.
//  DRAIN:
//   - o_redirect_valid=0, o_flush=1, o_busy=1.
//   - Bubble counter decrements each cycle; when it reaches 0 -> IDLE.
//   - Flush therefore lasts exactly FLUSH_CYCLES cycles after the handshake cycle.
//  Busy (REQ/DRAIN): i_ex_valid/i_jump_en ignored (wrong-path); no misalign pulses.
//  Counter:
//   - wraps modulo 2^CNT_W;
//   - i_cnt_clr sets it to 0 next cycle; clear wins over a simultaneous increment.
//  Reset mid-operation (REQ or DRAIN): next cycle IDLE, all outputs 0; the pending redirect is dropped.
//  Handshake and a new EX request in the same cycle: the new request is ignored (state was not IDLE).
// TESTING
//  1. Reset, i_ex_valid=1, i_jump_en=1, addr=0x0000_1000, i_ifu_ready=1, FLUSH_CYCLES=2
//     -> T+1: redirect_valid=1, pc=0x1000, flush=1; flush high T+1..T+3; idle at T+4; taken_cnt=1.
//  2. i_ifu_ready held 0 for 5 cycles after request, addr=0x2004
//     -> redirect_valid=1 and pc=0x2004 stable all 5 cycles; handshake on cycle 6; cnt+1.
//  3. Taken, addr=0x0000_1002
//     -> o_misalign=1 one cycle with addr 0x1002; redirect_valid=0, flush=0, taken_cnt unchanged.
//  4. Second taken request (addr 0x3000) during REQ/DRAIN
//     -> ignored; exactly one redirect (first target); taken_cnt+1 only.
//  5. i_rst=1 in REQ with pc=0x4000
//     -> next cycle all outputs 0, state IDLE; no handshake or count afterwards.
//  6. CNT_W=4, cnt=15, handshake -> cnt=0; cnt=5, i_cnt_clr with same-cycle handshake -> cnt=0.

Source files
------------

// File: rtl/exu_jump_ctrl.sv
// ============================================================================
// exu_jump_ctrl
// ----------------------------------------------------------------------------
// Converts a taken branch/jump result from the EXU into a front-end redirect.
// An aligned taken target is latched and offered to the IFU with a
// valid/ready handshake. Flush is held while the request is pending and for
// FLUSH_CYCLES bubble cycles after the handshake. Misaligned targets
// (addr[1:0] != 0) produce a one-cycle o_misalign pulse instead of a redirect.
// Completed handshakes are counted.
//
// Parameters
//   FLUSH_CYCLES : bubble cycles of flush after the handshake (0..15)
//   CNT_W        : width of the taken-redirect counter
//
// Ports
//   i_clk            : clock, all state changes on the rising edge
//   i_rst            : synchronous reset, active-high
//   i_ex_valid       : EX stage holds a valid instruction
//   i_jump_en        : branch/jump resolved taken (qualified by i_ex_valid)
//   i_jump_addr      : resolved target address
//   i_ifu_ready      : IFU accepts the redirect this cycle
//   i_cnt_clr        : clear the taken-redirect counter
//   o_redirect_valid : redirect request to the IFU
//   o_redirect_pc    : redirect target, stable while o_redirect_valid=1
//   o_flush          : kill wrong-path IF/ID instructions
//   o_busy           : controller not idle, EX requests ignored
//   o_misalign       : one-cycle pulse for a taken misaligned target
//   o_misalign_addr  : offending target, valid while o_misalign=1
//   o_taken_cnt      : number of completed redirect handshakes
// ============================================================================
module exu_jump_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ex_valid,
    input  logic             i_jump_en,
    input  logic [31:0]      i_jump_addr,
    input  logic             i_ifu_ready,
    input  logic             i_cnt_clr,
    output logic             o_redirect_valid,
    output logic [31:0]      o_redirect_pc,
    output logic             o_flush,
    output logic             o_busy,
    output logic             o_misalign,
    output logic [31:0]      o_misalign_addr,
    output logic [CNT_W-1:0] o_taken_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t           r_state;
    logic [3:0]       r_bubble;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic             r_flush;
    logic             r_busy;
    logic             r_misalign;
    logic [31:0]      r_misalign_addr;
    logic [CNT_W-1:0] r_taken_cnt;

    logic w_req;
    logic w_aligned;
    logic w_handshake;

    assign w_req       = i_ex_valid & i_jump_en;
    assign w_aligned   = (i_jump_addr[1:0] == 2'b00);
    // r_redirect_valid is only ever set in ST_REQ, so this is the REQ handshake.
    assign w_handshake = r_redirect_valid & i_ifu_ready;

    // NOTE: every output is a flop written with non-blocking assignments in this
    // one block; no input reaches an output combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= ST_IDLE;
            r_bubble         <= 4'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_flush          <= 1'b0;
            r_busy           <= 1'b0;
            r_misalign       <= 1'b0;
            r_misalign_addr  <= 32'd0;
            r_taken_cnt      <= '0;
        end else begin
            // Misalign is a pulse; it only survives the cycle it is set in.
            r_misalign <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_aligned) begin
                            r_state          <= ST_REQ;
                            r_redirect_pc    <= i_jump_addr;
                            r_redirect_valid <= 1'b1;
                            r_flush          <= 1'b1;
                            r_busy           <= 1'b1;
                        end else begin
                            r_misalign      <= 1'b1;
                            r_misalign_addr <= i_jump_addr;
                        end
                    end
                end

                ST_REQ: begin
                    // EX requests are wrong-path here and deliberately ignored.
                    if (w_handshake) begin
                        r_redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                            r_flush <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= ST_DRAIN;
                            r_bubble <= FLUSH_INIT;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Leave when the count is about to hit zero so flush stays
                    // high for exactly FLUSH_CYCLES cycles after the handshake.
                    r_bubble <= r_bubble - 4'd1;
                    if (r_bubble == 4'd1) begin
                        r_state <= ST_IDLE;
                        r_flush <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state          <= ST_IDLE;
                    r_redirect_valid <= 1'b0;
                    r_flush          <= 1'b0;
                    r_busy           <= 1'b0;
                end
            endcase

            // Clear has priority over a same-cycle increment.
            if (i_cnt_clr) begin
                r_taken_cnt <= '0;
            end else if (w_handshake) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush          = r_flush;
    assign o_busy           = r_busy;
    assign o_misalign       = r_misalign;
    assign o_misalign_addr  = r_misalign_addr;
    assign o_taken_cnt      = r_taken_cnt;

endmodule

// File: tb/tb_exu_jump_ctrl.sv
// ============================================================================
// tb_exu_jump_ctrl
// ----------------------------------------------------------------------------
// Directed bench for exu_jump_ctrl. A cycle-by-cycle vector table drives the
// main instance (FLUSH_CYCLES=2, CNT_W=32); hand-written sequences cover
// reset during REQ and, on a second instance (FLUSH_CYCLES=0, CNT_W=4),
// counter wrap and clear-versus-increment priority.
// ============================================================================
module tb_exu_jump_ctrl;

    logic        i_clk;
    logic        i_rst;

    // Main instance stimulus / observation
    logic        ev, je, rdy, clr;
    logic [31:0] addr;
    logic        o_valid, o_flush, o_busy, o_mis;
    logic [31:0] o_pc, o_mis_addr;
    logic [31:0] o_cnt;

    // Second instance (FLUSH_CYCLES=0, CNT_W=4)
    logic        d4_ev, d4_je, d4_rdy, d4_clr;
    logic [31:0] d4_addr;
    logic        d4_valid, d4_flush, d4_busy, d4_mis;
    logic [31:0] d4_pc, d4_mis_addr;
    logic [3:0]  d4_cnt;

    int n_total = 0;
    int n_bad   = 0;

    exu_jump_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_ex_valid       (ev),
        .i_jump_en        (je),
        .i_jump_addr      (addr),
        .i_ifu_ready      (rdy),
        .i_cnt_clr        (clr),
        .o_redirect_valid (o_valid),
        .o_redirect_pc    (o_pc),
        .o_flush          (o_flush),
        .o_busy           (o_busy),
        .o_misalign       (o_mis),
        .o_misalign_addr  (o_mis_addr),
        .o_taken_cnt      (o_cnt)
    );

    exu_jump_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) u_dut4 (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_ex_valid       (d4_ev),
        .i_jump_en        (d4_je),
        .i_jump_addr      (d4_addr),
        .i_ifu_ready      (d4_rdy),
        .i_cnt_clr        (d4_clr),
        .o_redirect_valid (d4_valid),
        .o_redirect_pc    (d4_pc),
        .o_flush          (d4_flush),
        .o_busy           (d4_busy),
        .o_misalign       (d4_mis),
        .o_misalign_addr  (d4_mis_addr),
        .o_taken_cnt      (d4_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ev;
        logic        je;
        logic [31:0] addr;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_busy;
        logic        e_mis;
        logic [31:0] e_mis_addr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs are changed on the falling edge; outputs are sampled on the
    // falling edge that follows the next rising edge.
    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    function automatic vec_t mk(
        input logic ev_i, input logic je_i, input logic [31:0] addr_i,
        input logic rdy_i, input logic clr_i,
        input logic v, input logic [31:0] pc, input logic f, input logic b,
        input logic m, input logic [31:0] ma, input logic [31:0] c);
        vec_t r;
        r.ev = ev_i; r.je = je_i; r.addr = addr_i; r.rdy = rdy_i; r.clr = clr_i;
        r.e_valid = v; r.e_pc = pc; r.e_flush = f; r.e_busy = b;
        r.e_mis = m; r.e_mis_addr = ma; r.e_cnt = c;
        return r;
    endfunction

    // One redirect on the FLUSH_CYCLES=0 instance; optional clear on the handshake.
    task automatic d4_redirect(input logic [31:0] a, input logic clr_on_hs, input string tag);
        d4_ev = 1'b1; d4_je = 1'b1; d4_addr = a; d4_rdy = 1'b0; d4_clr = 1'b0;
        step();
        check({tag, " req valid"}, 32'(d4_valid), 32'd1);
        d4_ev = 1'b0; d4_je = 1'b0; d4_rdy = 1'b1; d4_clr = clr_on_hs;
        step();
        d4_rdy = 1'b0; d4_clr = 1'b0;
        check({tag, " hs valid"}, 32'(d4_valid), 32'd0);
        check({tag, " hs flush"}, 32'(d4_flush), 32'd0);
        check({tag, " hs busy"},  32'(d4_busy),  32'd0);
    endtask

    initial begin
        // ---------------- vector table (main instance) ----------------
        //            ev  je  addr          rdy clr | val pc            fl  bs  mis mis_addr      cnt
        // Test 1: aligned taken with immediate ready
        vecs.push_back(mk(1, 1, 32'h0000_1000, 1, 0, 1, 32'h0000_1000, 1, 1, 0, 32'h0, 1 - 1));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 32'h0000_1000, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0000_1000, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0000_1000, 0, 0, 0, 32'h0, 1));
        // Unqualified requests are ignored
        vecs.push_back(mk(1, 0, 32'h0000_5000, 0, 0, 0, 32'h0000_1000, 0, 0, 0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h0000_6000, 0, 0, 0, 32'h0000_1000, 0, 0, 0, 32'h0, 1));
        // Test 3: misaligned targets pulse o_misalign only
        vecs.push_back(mk(1, 1, 32'h0000_1002, 1, 0, 0, 32'h0000_1000, 0, 0, 1, 32'h0000_1002, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0000_1000, 0, 0, 0, 32'h0, 1));
        vecs.push_back(mk(1, 1, 32'h0000_1003, 0, 0, 0, 32'h0000_1000, 0, 0, 1, 32'h0000_1003, 1));
        vecs.push_back(mk(1, 1, 32'h0000_1001, 0, 0, 0, 32'h0000_1000, 0, 0, 1, 32'h0000_1001, 1));
        // Test 2 + 4: IFU stalls 5 cycles; new requests while busy are ignored
        vecs.push_back(mk(1, 1, 32'h0000_2004, 0, 0, 1, 32'h0000_2004, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_2004, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(1, 1, 32'h0000_3000, 0, 0, 1, 32'h0000_2004, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(1, 1, 32'h0000_3001, 0, 0, 1, 32'h0000_2004, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_2004, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(1, 1, 32'h0000_3000, 0, 0, 1, 32'h0000_2004, 1, 1, 0, 32'h0, 1));
        // Handshake on the 6th cycle together with a new request
        vecs.push_back(mk(1, 1, 32'h0000_3000, 1, 0, 0, 32'h0000_2004, 1, 1, 0, 32'h0, 2));
        vecs.push_back(mk(1, 1, 32'h0000_3000, 1, 0, 0, 32'h0000_2004, 1, 1, 0, 32'h0, 2));
        vecs.push_back(mk(1, 1, 32'h0000_7000, 0, 0, 0, 32'h0000_2004, 0, 0, 0, 32'h0, 2));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0000_2004, 0, 0, 0, 32'h0, 2));
        // Counter clear, then clear coinciding with a handshake
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 32'h0000_2004, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 32'h0000_8000, 1, 0, 1, 32'h0000_8000, 1, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0, 32'h0000_8000, 1, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0000_8000, 1, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0000_8000, 0, 0, 0, 32'h0, 0));

        // ---------------- reset ----------------
        ev = 0; je = 0; addr = '0; rdy = 0; clr = 0;
        d4_ev = 0; d4_je = 0; d4_addr = '0; d4_rdy = 0; d4_clr = 0;
        i_rst = 1'b1;
        step();
        step();
        check("rst valid",    32'(o_valid), 32'd0);
        check("rst pc",       o_pc,         32'd0);
        check("rst flush",    32'(o_flush), 32'd0);
        check("rst busy",     32'(o_busy),  32'd0);
        check("rst mis",      32'(o_mis),   32'd0);
        check("rst mis_addr", o_mis_addr,   32'd0);
        check("rst cnt",      o_cnt,        32'd0);
        check("rst d4 cnt",   32'(d4_cnt),  32'd0);
        i_rst = 1'b0;

        // ---------------- table-driven run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            ev = vecs[i].ev; je = vecs[i].je; addr = vecs[i].addr;
            rdy = vecs[i].rdy; clr = vecs[i].clr;
            step();
            check($sformatf("v%0d valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d pc", i),    o_pc,         vecs[i].e_pc);
            check($sformatf("v%0d flush", i), 32'(o_flush), 32'(vecs[i].e_flush));
            check($sformatf("v%0d busy", i),  32'(o_busy),  32'(vecs[i].e_busy));
            check($sformatf("v%0d mis", i),   32'(o_mis),   32'(vecs[i].e_mis));
            if (vecs[i].e_mis)
                check($sformatf("v%0d mis_addr", i), o_mis_addr, vecs[i].e_mis_addr);
            check($sformatf("v%0d cnt", i),   o_cnt,        vecs[i].e_cnt);
        end

        // ---------------- Test 5: reset while in REQ ----------------
        ev = 1; je = 1; addr = 32'h0000_4000; rdy = 0; clr = 0;
        step();
        ev = 0; je = 0;
        check("t5 req valid", 32'(o_valid), 32'd1);
        check("t5 req pc",    o_pc,         32'h0000_4000);
        step();
        check("t5 hold valid", 32'(o_valid), 32'd1);
        i_rst = 1'b1; rdy = 1;
        step();
        i_rst = 1'b0;
        check("t5 rst valid",    32'(o_valid), 32'd0);
        check("t5 rst pc",       o_pc,         32'd0);
        check("t5 rst flush",    32'(o_flush), 32'd0);
        check("t5 rst busy",     32'(o_busy),  32'd0);
        check("t5 rst mis",      32'(o_mis),   32'd0);
        check("t5 rst mis_addr", o_mis_addr,   32'd0);
        check("t5 rst cnt",      o_cnt,        32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t5 post%0d valid", k), 32'(o_valid), 32'd0);
            check($sformatf("t5 post%0d flush", k), 32'(o_flush), 32'd0);
            check($sformatf("t5 post%0d busy", k),  32'(o_busy),  32'd0);
            check($sformatf("t5 post%0d cnt", k),   o_cnt,        32'd0);
        end
        rdy = 0;

        // ---------------- Test 6: 4-bit counter wrap and clear priority ----------------
        for (int k = 0; k < 15; k++) begin
            d4_redirect(32'h0000_0100 + 32'(k) * 4, 1'b0, $sformatf("t6 r%0d", k));
            check($sformatf("t6 r%0d cnt", k), 32'(d4_cnt), 32'(k + 1));
        end
        d4_redirect(32'h0000_0200, 1'b0, "t6 wrap");
        check("t6 wrap cnt", 32'(d4_cnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            d4_redirect(32'h0000_0300 + 32'(k) * 4, 1'b0, $sformatf("t6 s%0d", k));
        end
        check("t6 cnt5", 32'(d4_cnt), 32'd5);
        d4_redirect(32'h0000_0400, 1'b1, "t6 clr");
        check("t6 clr cnt", 32'(d4_cnt), 32'd0);
        check("t6 pc", d4_pc, 32'h0000_0400);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
